// File: rtl/gpio_pad_ctrl_if.sv
// Register-side bus of the GPIO pad controller: control/data in, pad and
// filtered-pin status out. The master drives the registers; the slave is the pad block.
interface gpio_pad_ctrl_if;
  logic [31:0] ctrl_i;
  logic [31:0] data_i;
  logic [1:0]  pad_in_i;
  logic [1:0]  pad_out_o;
  logic [1:0]  pad_oe_o;
  logic [1:0]  pin_o;
  logic [1:0]  edge_o;
  logic [1:0]  irq_clr_i;
  logic        irq_o;

  modport master (
    output ctrl_i, data_i, pad_in_i, irq_clr_i,
    input  pad_out_o, pad_oe_o, pin_o, edge_o, irq_o
  );

  modport slave (
    input  ctrl_i, data_i, pad_in_i, irq_clr_i,
    output pad_out_o, pad_oe_o, pin_o, edge_o, irq_o
  );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// Two-pin GPIO pad controller: output drive, 2-flop input sync, optional debounce
// (compile with GPIO_DEBOUNCE_EN), edge detect and sticky interrupt pending bits.
module gpio_pad_ctrl #(
  parameter int unsigned DB_CYCLES = 16
) (
  input logic           clk,
  input logic           rst,
  gpio_pad_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_HIZ = 2'd0,
    MODE_OUT = 2'd1,
    MODE_IN  = 2'd2,
    MODE_RSV = 2'd3
  } pin_mode_e;

  logic [1:0] s1, s2;
  logic [1:0] pin_q, pin_nxt;
  logic [1:0] edge_q, edge_nxt;
  logic [1:0] pend_q, pend_nxt;
  logic       irq_q;
  logic [1:0] oe;

  logic unused_bits;
  assign unused_bits = ^{bus.ctrl_i[31:4], bus.data_i[31:2]};

  for (genvar g = 0; g < 2; g++) begin : g_pin
    pin_mode_e mode;
    assign mode         = pin_mode_e'(bus.ctrl_i[2*g +: 2]);
    assign oe[g]        = (mode == MODE_OUT);
    assign edge_nxt[g]  = (pin_nxt[g] != pin_q[g]) && (mode == MODE_IN);

`ifdef GPIO_DEBOUNCE_EN
    logic [7:0] cnt, cnt_nxt;
    logic       pin_n;

    // Counter restarts whenever the synced level agrees with the accepted one,
    // so only an uninterrupted run of DB_CYCLES disagreeing cycles is accepted.
    always_comb begin
      pin_n   = pin_q[g];
      cnt_nxt = '0;
      if (s2[g] != pin_q[g]) begin
        if (cnt == 8'(DB_CYCLES - 1)) begin
          pin_n = s2[g];
        end else if (cnt != '1) begin
          cnt_nxt = cnt + 8'd1;
        end else begin
          cnt_nxt = cnt;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt_nxt;
    end

    assign pin_nxt[g] = pin_n;
`else
    assign pin_nxt[g] = s2[g];
`endif
  end

`ifndef GPIO_DEBOUNCE_EN
  logic [7:0] unused_db;
  assign unused_db = 8'(DB_CYCLES);
`endif

  // Set has priority over a simultaneous write-1-to-clear.
  assign pend_nxt = (pend_q & ~bus.irq_clr_i) | edge_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      pin_q  <= '0;
      edge_q <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      s1     <= bus.pad_in_i;
      s2     <= s1;
      pin_q  <= pin_nxt;
      edge_q <= edge_nxt;
      pend_q <= pend_nxt;
      irq_q  <= |pend_nxt;
    end
  end

  assign bus.pad_oe_o  = oe;
  assign bus.pad_out_o = bus.data_i[1:0] & oe;
  assign bus.pin_o     = pin_q;
  assign bus.edge_o    = edge_q;
  assign bus.irq_o     = irq_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl with DB_CYCLES = 4; expected pad-to-pin
// latency follows GPIO_DEBOUNCE_EN (2 + DB_CYCLES with debounce, 3 without).
module tb_gpio_pad_ctrl;

  localparam int unsigned DB = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT   = 2 + DB;
  localparam bit DB_EN = 1'b1;
`else
  localparam int LAT   = 3;
  localparam bit DB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [1:0] acc_pin, acc_edge, acc_irq;

  always #5 clk = ~clk;

  gpio_pad_ctrl_if bus ();

  gpio_pad_ctrl #(.DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.ctrl_i    = '0;
    bus.data_i    = '0;
    bus.pad_in_i  = '0;
    bus.irq_clr_i = '0;

    // Reset state
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("rst_pin",  32'(bus.pin_o),    32'h0);
    chk("rst_edge", 32'(bus.edge_o),   32'h0);
    chk("rst_irq",  32'(bus.irq_o),    32'h0);
    chk("rst_oe",   32'(bus.pad_oe_o), 32'h0);

    // Output drive and mode decode
    bus.ctrl_i = 32'h1; bus.data_i = 32'h1; #1;
    chk("out_oe",  32'(bus.pad_oe_o),  32'h1);
    chk("out_lvl", 32'(bus.pad_out_o), 32'h1);
    bus.ctrl_i = 32'h3; #1;
    chk("rsv_oe",  32'(bus.pad_oe_o),  32'h0);
    chk("rsv_lvl", 32'(bus.pad_out_o), 32'h0);
    bus.ctrl_i = 32'hFFFF_FFF4; bus.data_i = 32'hFFFF_FFFE; #1;
    chk("hi_oe",  32'(bus.pad_oe_o),  32'h2);
    chk("hi_lvl", 32'(bus.pad_out_o), 32'h2);
    bus.ctrl_i = 32'h5; bus.data_i = 32'h2; #1;
    chk("both_oe",  32'(bus.pad_oe_o),  32'h3);
    chk("both_lvl", 32'(bus.pad_out_o), 32'h2);
    bus.ctrl_i = 32'h0; bus.data_i = 32'h0;

    // Input rise on pin 0 in input mode
    bus.ctrl_i = 32'h2;
    bus.pad_in_i = 2'b01;
    tick(LAT - 1);
    chk("rise_pin_early", 32'(bus.pin_o),  32'h0);
    chk("rise_irq_early", 32'(bus.irq_o),  32'h0);
    tick(1);
    chk("rise_pin",  32'(bus.pin_o),  32'h1);
    chk("rise_edge", 32'(bus.edge_o), 32'h1);
    chk("rise_irq",  32'(bus.irq_o),  32'h1);
    tick(1);
    chk("rise_edge_end", 32'(bus.edge_o), 32'h0);
    chk("rise_irq_hold", 32'(bus.irq_o),  32'h1);

    // Set beats clear on the same edge, then a lone clear
    bus.pad_in_i = 2'b00;
    tick(LAT - 1);
    chk("fall_pin_early", 32'(bus.pin_o), 32'h1);
    bus.irq_clr_i = 2'b01;
    tick(1);
    chk("fall_pin",      32'(bus.pin_o),  32'h0);
    chk("fall_edge",     32'(bus.edge_o), 32'h1);
    chk("set_wins_irq",  32'(bus.irq_o),  32'h1);
    tick(1);
    chk("clr_irq",       32'(bus.irq_o),  32'h0);
    chk("clr_edge",      32'(bus.edge_o), 32'h0);
    bus.irq_clr_i = 2'b00;

    // Three-cycle glitch on pin 1 in input mode
    bus.ctrl_i = 32'h8;
    acc_pin = '0; acc_edge = '0;
    for (int i = 0; i < 10; i++) begin
      bus.pad_in_i = (i < 3) ? 2'b10 : 2'b00;
      tick(1);
      acc_pin  |= bus.pin_o;
      acc_edge |= bus.edge_o;
    end
    chk("glitch_pin",  32'(acc_pin[1]),  DB_EN ? 32'h0 : 32'h1);
    chk("glitch_edge", 32'(acc_edge[1]), DB_EN ? 32'h0 : 32'h1);
    chk("glitch_irq",  32'(bus.irq_o),   DB_EN ? 32'h0 : 32'h1);
    bus.irq_clr_i = 2'b11;
    tick(1);
    bus.irq_clr_i = 2'b00;
    chk("glitch_clr_irq", 32'(bus.irq_o), 32'h0);

    // Hi-Z mode: pin still filtered, but no edge or irq
    bus.ctrl_i = 32'h0;
    bus.pad_in_i = 2'b01;
    acc_edge = '0; acc_irq = '0;
    for (int i = 0; i < LAT; i++) begin
      if (i == LAT - 1) chk("hiz_pin_early", 32'(bus.pin_o), 32'h0);
      tick(1);
      acc_edge |= bus.edge_o;
      acc_irq  |= {1'b0, bus.irq_o};
    end
    chk("hiz_pin",  32'(bus.pin_o), 32'h1);
    chk("hiz_edge", 32'(acc_edge),  32'h0);
    chk("hiz_irq",  32'(acc_irq),   32'h0);

    // Reset mid-count with the pad held high
    bus.pad_in_i = 2'b00;
    tick(LAT + 1);
    chk("pre_rst_pin", 32'(bus.pin_o), 32'h0);
    bus.pad_in_i = 2'b01;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_pin",  32'(bus.pin_o),    32'h0);
    chk("mid_rst_edge", 32'(bus.edge_o),   32'h0);
    chk("mid_rst_irq",  32'(bus.irq_o),    32'h0);
    chk("mid_rst_oe",   32'(bus.pad_oe_o), 32'h0);
    tick(LAT - 1);
    chk("post_rst_pin_early", 32'(bus.pin_o), 32'h0);
    tick(1);
    chk("post_rst_pin", 32'(bus.pin_o), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_pad_ctrl.md
GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 16, giving the number of consecutive stable synchronized cycles needed to accept a new input level (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port ctrl_i, input, 32 bits: GPIO control register, 2 bits per pin; [1:0] is pin 0 and [3:2] is pin 1; 0 = hi-Z, 1 = output, 2 = input, 3 = reserved (treated as hi-Z).
REQ-005 SHALL have port data_i, input, 32 bits: GPIO data register; bit n is the output level of pin n.
REQ-006 SHALL have port pad_in_i, input, 2 bits: asynchronous pad input levels.
REQ-007 SHALL have port pad_out_o, output, 2 bits: pad output level.
REQ-008 SHALL have port pad_oe_o, output, 2 bits: pad output enable, 1 = drive.
REQ-009 SHALL have port pin_o, output, 2 bits: synchronized, filtered input level; feeds the GPIO register block input pins.
REQ-010 SHALL have port edge_o, output, 2 bits: one-cycle pulse on any accepted level change of pin n while pin n is in input mode.
REQ-011 SHALL have port irq_clr_i, input, 2 bits: write-1-to-clear for the pending bits.
REQ-012 SHALL have port irq_o, output, 1 bit: OR of the 2 pending bits.

Function
REQ-013 SHALL drive pad_oe_o[n] = 1 combinationally only when the mode of pin n equals 1.
REQ-014 SHALL drive pad_out_o[n] = data_i[n] when pad_oe_o[n] = 1, and 0 otherwise.
REQ-015 SHALL pass each pad_in_i bit through a 2-flop synchronizer (s1 then s2) on every cycle, regardless of mode.
REQ-016 SHALL keep one saturating counter per pin, 8 bits wide.
REQ-017 SHALL clear the counter in any cycle where s2[n] equals pin_o[n].
REQ-018 SHALL increment the counter otherwise.
REQ-019 SHALL, on the edge where the counter would reach DB_CYCLES, load pin_o[n] with s2[n] and clear the counter in the same edge.
REQ-020 SHALL give, with debounce compiled in, a latency from a stable pad change to pin_o of 2 + DB_CYCLES rising edges.
REQ-021 SHALL filter out glitches shorter than DB_CYCLES synchronized cycles completely.
REQ-022 SHALL register edge_o[n] high for exactly the one cycle following the pin_o[n] update, and only if the mode of pin n equals 2 at the update edge.
REQ-023 SHALL keep the debounce counters and pin_o running in every mode; a mode change SHALL NOT reset them.
REQ-024 SHALL set pending[n] on the edge where edge_o[n] is set, and clear pending[n] on the edge after irq_clr_i[n] = 1.
REQ-025 SHALL let set win over clear when both occur on the same edge.
REQ-026 SHALL register irq_o as the OR of the pending bits; it follows pending with no extra delay.
REQ-027 SHALL ignore ctrl_i bits [31:4] and data_i bits [31:2].

Reset
REQ-028 SHALL, while rst = 1 at a rising edge, clear s1, s2, counters, pin_o, edge_o, pending and irq_o to 0.
REQ-029 SHALL keep pad_oe_o and pad_out_o combinational from ctrl_i and data_i, so they read 0 whenever the upstream registers are 0.
REQ-030 SHALL abort any debounce in progress when reset is asserted mid-count; a pad held at 1 through reset SHALL be re-accepted 2 + DB_CYCLES edges after rst falls.

Configuration
REQ-031 SHALL, when macro GPIO_DEBOUNCE_EN is defined, instantiate the counters and apply REQ-016 to REQ-021.
REQ-032 SHALL, when GPIO_DEBOUNCE_EN is undefined, remove the counters and load pin_o from s2 on every edge, giving a latency of 3 rising edges from the pad to pin_o; edge, irq and reset behaviour SHALL otherwise be unchanged.

Verification
REQ-033 SHALL check: ctrl_i = 0x1, data_i = 0x1 -> pad_oe_o = 2'b01 and pad_out_o = 2'b01; then ctrl_i = 0x3 -> pad_oe_o = 2'b00 and pad_out_o = 2'b00.
REQ-034 SHALL check: with DB_CYCLES = 4, debounce enabled and ctrl_i = 0x2, pad_in_i[0] rises and is held -> pin_o[0] = 1 exactly 6 edges later, edge_o[0] is a single-cycle pulse, and irq_o = 1.
REQ-035 SHALL check: with DB_CYCLES = 4, a 3-cycle high glitch on pad_in_i[1] with ctrl_i = 0x8 -> pin_o[1] stays 0 and edge_o and irq_o stay 0.
REQ-036 SHALL check: pending[0] = 1 and irq_clr_i = 2'b01 asserted on the same edge as a new edge_o[0] -> pending[0] stays 1; then a lone clear -> irq_o = 0 one edge later.
REQ-037 SHALL check: with ctrl_i = 0x0 (hi-Z) and a pad toggle -> pin_o follows after debounce, while edge_o and irq_o stay 0.
REQ-038 SHALL check: rst pulsed at count 2 of 4 with the pad held high -> all outputs are 0 after reset, and pin_o = 1 exactly 6 edges after rst falls.
